// File: rtl/dmg_bus_responder.sv
// Memory-mapped RAM responder for a DMG-style core bus, with a write-log FIFO and access counters.
// Reads answer combinationally; writes commit the cycle after the strobe drops; log is popped on demand, drops when full.
module dmg_bus_responder #(
  parameter int          RAM_AW    = 8,
  parameter logic [15:0] RAM_BASE  = 16'hC000,
  parameter logic [7:0]  FILL      = 8'h00,
  parameter int          LOG_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        MREQ,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] A,
  inout  wire  [7:0]  D,
  input  logic        LOG_POP,
  output logic        LOG_VALID,
  output logic [15:0] LOG_ADDR,
  output logic [7:0]  LOG_DATA,
  output logic        LOG_OVF,
  output logic        CONFLICT,
  output logic [15:0] RD_COUNT,
  output logic [15:0] WR_COUNT
);

  localparam int          RAM_SZ  = 1 << RAM_AW;
  localparam int          PW      = $clog2(LOG_DEPTH);
  localparam logic [16:0] WIN_SZ  = 17'(RAM_SZ);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(LOG_DEPTH);

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dat;
  } log_ent_t;

  logic        rd_vld, wr_vld, cf_vld;
  logic [15:0] a_off;
  logic        a_in_win;
  logic [7:0]  rd_dat;
  logic [7:0]  ram [RAM_SZ];

  assign rd_vld = MREQ & RD & ~WR;
  assign wr_vld = MREQ & WR & ~RD;
  assign cf_vld = MREQ & RD & WR;

  // Window test uses the wrapped 16-bit offset so addresses below the base fall outside.
  assign a_off    = A - RAM_BASE;
  assign a_in_win = {1'b0, a_off} < WIN_SZ;
  assign rd_dat   = a_in_win ? ram[a_off[RAM_AW-1:0]] : FILL;
  assign D        = rd_vld ? rd_dat : 8'hzz;

  logic        wr_q;
  log_ent_t    pend;
  logic        commit;
  logic [15:0] pend_off;
  logic        pend_in_win;

  assign commit      = wr_q & ~wr_vld & ~cf_vld;
  assign pend_off    = pend.addr - RAM_BASE;
  assign pend_in_win = {1'b0, pend_off} < WIN_SZ;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_q <= 1'b0;
      pend <= '0;
    end else if (cf_vld) begin
      wr_q <= 1'b0;
    end else if (wr_vld) begin
      wr_q <= 1'b1;
      pend <= {A, D};
    end else if (commit) begin
      wr_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (commit && pend_in_win) ram[pend_off[RAM_AW-1:0]] <= pend.dat;
  end

  log_ent_t      log_mem [LOG_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   log_cnt;
  logic          pop_vld, push_vld, log_full;

  // A simultaneous pop frees the head slot, so a push into a full log still lands.
  assign pop_vld  = LOG_POP & (log_cnt != '0);
  assign log_full = log_cnt == DEPTH_C;
  assign push_vld = commit & (~log_full | pop_vld);

  always_ff @(posedge CLK) begin
    if (push_vld) log_mem[wr_ptr] <= pend;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      log_cnt <= '0;
      LOG_OVF <= 1'b0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      if (push_vld && !pop_vld)      log_cnt <= log_cnt + 1'b1;
      else if (!push_vld && pop_vld) log_cnt <= log_cnt - 1'b1;
      if (commit && !push_vld) LOG_OVF <= 1'b1;
    end
  end

  assign LOG_VALID            = log_cnt != '0;
  assign {LOG_ADDR, LOG_DATA} = LOG_VALID ? log_mem[rd_ptr] : '0;

  logic rd_q;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rd_q     <= 1'b0;
      CONFLICT <= 1'b0;
      RD_COUNT <= '0;
      WR_COUNT <= '0;
    end else begin
      rd_q <= rd_vld;
      if (cf_vld) CONFLICT <= 1'b1;
      if (rd_vld && !rd_q && RD_COUNT != 16'hFFFF) RD_COUNT <= RD_COUNT + 16'd1;
      if (commit && WR_COUNT != 16'hFFFF)          WR_COUNT <= WR_COUNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmg_bus_responder.sv
// Directed bench for dmg_bus_responder: queue/array reference model checked every cycle, plus literal expectations.
module tb_dmg_bus_responder;

  localparam logic [15:0] BASE   = 16'hC000;
  localparam logic [7:0]  FILL_B = 8'h00;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        MREQ = 1'b0, RD = 1'b0, WR = 1'b0, LOG_POP = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [7:0]  d_drv = 8'h00;
  logic        d_oe = 1'b0;
  wire  [7:0]  D;
  logic        LOG_VALID, LOG_OVF, CONFLICT;
  logic [15:0] LOG_ADDR, RD_COUNT, WR_COUNT;
  logic [7:0]  LOG_DATA;

  assign D = d_oe ? d_drv : 8'hzz;

  dmg_bus_responder #(
    .RAM_AW(8), .RAM_BASE(BASE), .FILL(FILL_B), .LOG_DEPTH(8)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .MREQ(MREQ), .RD(RD), .WR(WR), .A(A), .D(D),
    .LOG_POP(LOG_POP), .LOG_VALID(LOG_VALID), .LOG_ADDR(LOG_ADDR), .LOG_DATA(LOG_DATA),
    .LOG_OVF(LOG_OVF), .CONFLICT(CONFLICT), .RD_COUNT(RD_COUNT), .WR_COUNT(WR_COUNT)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b1;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: RAM bytes known to the bench, log as a queue, plain counters.
  typedef struct { logic [15:0] a; logic [7:0] d; } ent_t;
  ent_t        m_q[$];
  logic [7:0]  m_ram [int];
  bit          m_pend, m_ovf, m_conf, m_rdprev;
  logic [15:0] m_pa, m_rdc = 16'h0, m_wrc = 16'h0;
  logic [7:0]  m_pd;

  function automatic bit in_win(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    return off < 16'd256;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend = 0; m_ovf = 0; m_conf = 0; m_rdprev = 0;
    m_rdc = 16'h0; m_wrc = 16'h0;
  endtask

  task automatic model_step();
    bit rd_a, wr_a, cf, pop_ok;
    int orig;
    logic [15:0] off;
    ent_t e;
    rd_a   = MREQ && RD && !WR;
    wr_a   = MREQ && WR && !RD;
    cf     = MREQ && RD && WR;
    orig   = m_q.size();
    pop_ok = LOG_POP && orig > 0;
    if (pop_ok) m_q.delete(0);
    if (cf) begin
      m_conf = 1; m_pend = 0;
    end else if (wr_a) begin
      m_pend = 1; m_pa = A; m_pd = D;
    end else if (m_pend) begin
      m_pend = 0;
      off = m_pa - BASE;
      if (in_win(m_pa)) m_ram[int'(off)] = m_pd;
      if (orig < 8 || pop_ok) begin
        e.a = m_pa; e.d = m_pd;
        m_q.push_back(e);
      end else m_ovf = 1;
      if (m_wrc != 16'hFFFF) m_wrc++;
    end
    if (rd_a && !m_rdprev && m_rdc != 16'hFFFF) m_rdc++;
    m_rdprev = rd_a;
  endtask

  initial forever begin
    @(posedge CLK or negedge nRESET);
    if (!nRESET) model_reset();
    else model_step();
  end

  task automatic compare_all();
    logic [15:0] off;
    check("log_valid", LOG_VALID, m_q.size() != 0);
    check("log_addr", LOG_ADDR, m_q.size() != 0 ? m_q[0].a : 16'h0);
    check("log_data", LOG_DATA, m_q.size() != 0 ? {8'h0, m_q[0].d} : 16'h0);
    check("log_ovf", LOG_OVF, m_ovf);
    check("conflict", CONFLICT, m_conf);
    check("rd_count", RD_COUNT, m_rdc);
    check("wr_count", WR_COUNT, m_wrc);
    off = A - BASE;
    if (MREQ && RD && !WR) begin
      if (!in_win(A)) check("d_fill", D, FILL_B);
      else if (m_ram.exists(int'(off))) check("d_ram", D, m_ram[int'(off)]);
    end else if (d_oe) begin
      check("d_bus", D, d_drv);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    if (cmp_en) compare_all();
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    MREQ = 0; RD = 0; WR = 0; LOG_POP = 0; d_oe = 0;
  endtask

  task automatic write(input logic [15:0] addr, input logic [7:0] dat, input int n);
    MREQ = 1; WR = 1; RD = 0; A = addr; d_drv = dat; d_oe = 1;
    repeat (n) tick();
    idle();
    tick();
  endtask

  task automatic read_chk(input logic [15:0] addr, input logic [7:0] exp, input string nm);
    MREQ = 1; RD = 1; WR = 0; A = addr;
    @(negedge CLK);
    check(nm, D, exp);
    tick(); idle(); tick();
  endtask

  task automatic pop(input int n);
    LOG_POP = 1;
    repeat (n) tick();
    LOG_POP = 0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_log_valid", LOG_VALID, 0);
    check("rst_log_addr", LOG_ADDR, 0);
    check("rst_rd_count", RD_COUNT, 0);
    check("rst_wr_count", WR_COUNT, 0);
    check("rst_conflict", CONFLICT, 0);
    @(posedge CLK); #3 nRESET = 1;
    tick();

    // basic write then read
    write(16'hC005, 8'h5A, 2);
    MREQ = 1; RD = 1; A = 16'hC005;
    @(negedge CLK);
    check("t1_d", D, 8'h5A);
    check("t1_log_valid", LOG_VALID, 1);
    check("t1_log_addr", LOG_ADDR, 16'hC005);
    check("t1_log_data", LOG_DATA, 8'h5A);
    check("t1_wr_count", WR_COUNT, 1);
    tick(); idle();
    @(negedge CLK);
    check("t1_rd_count", RD_COUNT, 1);
    tick();

    // fill byte, undriven bus, out-of-window write
    pop(1);
    read_chk(16'h0000, 8'h00, "t2_fill");
    MREQ = 0; RD = 1; A = 16'hC005; d_drv = 8'h00; d_oe = 1;
    @(negedge CLK);
    check("t2_noreq_d", D, 8'h00);
    tick(); idle(); tick();
    write(16'hC080, 8'h00, 1);
    write(16'hFF80, 8'h11, 1);
    pop(1);
    @(negedge CLK);
    check("t2_oow_addr", LOG_ADDR, 16'hFF80);
    check("t2_oow_data", LOG_DATA, 8'h11);
    check("t2_wr_count", WR_COUNT, 3);
    read_chk(16'hC080, 8'h00, "t2_no_alias");
    read_chk(16'hFF80, 8'h00, "t2_oow_read");
    pop(1);
    @(negedge CLK);
    check("t2_log_empty", LOG_VALID, 0);

    // overflow, push+pop at full, pop while empty
    for (int i = 0; i < 9; i++) write(16'hC010 + 16'(i), 8'h20 + 8'(i), 1);
    @(negedge CLK);
    check("t3_ovf", LOG_OVF, 1);
    check("t3_head_addr", LOG_ADDR, 16'hC010);
    check("t3_head_data", LOG_DATA, 8'h20);
    check("t3_wr_count", WR_COUNT, 12);
    MREQ = 1; WR = 1; A = 16'hC019; d_drv = 8'h29; d_oe = 1;
    tick(); idle(); LOG_POP = 1; tick(); LOG_POP = 0;
    @(negedge CLK);
    check("t3_pp_addr", LOG_ADDR, 16'hC011);
    check("t3_pp_data", LOG_DATA, 8'h21);
    pop(7);
    @(negedge CLK);
    check("t3_tail_addr", LOG_ADDR, 16'hC019);
    check("t3_tail_data", LOG_DATA, 8'h29);
    pop(1);
    @(negedge CLK);
    check("t3_drained", LOG_VALID, 0);
    pop(1);
    write(16'hC020, 8'h33, 1);
    @(negedge CLK);
    check("t3_after_empty_pop_vld", LOG_VALID, 1);
    check("t3_after_empty_pop_addr", LOG_ADDR, 16'hC020);
    pop(1);

    // conflict discards pending write
    MREQ = 1; WR = 1; A = 16'hC005; d_drv = 8'h5A; d_oe = 1;
    tick();
    RD = 1; d_drv = 8'h00;
    @(negedge CLK);
    check("t4_d_undriven", D, 8'h00);
    tick(); idle();
    @(negedge CLK);
    check("t4_conflict", CONFLICT, 1);
    tick();
    @(negedge CLK);
    check("t4_no_log", LOG_VALID, 0);
    check("t4_wr_count", WR_COUNT, 14);

    // reset during a pending write
    write(16'hC041, 8'h12, 1);
    MREQ = 1; WR = 1; A = 16'hC040; d_drv = 8'h99; d_oe = 1;
    tick();
    #2 nRESET = 0;
    @(negedge CLK);
    check("t5_rd_count", RD_COUNT, 0);
    check("t5_wr_count", WR_COUNT, 0);
    check("t5_log_valid", LOG_VALID, 0);
    check("t5_log_addr", LOG_ADDR, 0);
    check("t5_conflict", CONFLICT, 0);
    @(posedge CLK); #1 idle();
    @(posedge CLK); #3 nRESET = 1;
    tick(); tick();
    read_chk(16'hC005, 8'h5A, "t5_ram_kept");
    @(negedge CLK);
    check("t5_no_log", LOG_VALID, 0);
    check("t5_wr_count_after", WR_COUNT, 0);

    // read counter saturation
    cmp_en = 0;
    for (int i = 0; i < 65537; i++) begin
      MREQ = 1; RD = 1; A = 16'hC005;
      tick(); idle(); tick();
      if (i % 8192 == 0) begin
        @(negedge CLK);
        check("t6_rd_count_bulk", RD_COUNT, m_rdc);
      end
    end
    @(negedge CLK);
    check("t6_rd_sat", RD_COUNT, 16'hFFFF);
    cmp_en = 1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
